// File: rtl/omsp_spm_pkg.sv
// Shared definitions for the SM protection command sequencer:
// state encoding, command opcodes, completion status codes and default sizes.
package omsp_spm_pkg;

    localparam int KEY_WORDS_DEF    = 4;
    localparam int KEY_IDX_SIZE_DEF = 2;
    localparam int TIMEOUT_DEF      = 255;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UPDATE  = 3'd1,
        S_CHECK   = 3'd2,
        S_KEYLOAD = 3'd3,
        S_VERIFY  = 3'd4,
        S_DONE    = 3'd5
    } spm_state_t;

    localparam logic [1:0] OP_PROTECT   = 2'b00;
    localparam logic [1:0] OP_UNPROTECT = 2'b01;
    localparam logic [1:0] OP_VERIFY    = 2'b10;
    localparam logic [1:0] OP_RESERVED  = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_VIOL    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_BADOP   = 2'b11;

endpackage

// File: rtl/omsp_spm_key_stream.sv
// Key streaming stage: accepts derived key words from the key-derivation
// engine and writes them into the SPM array one word per write_key strobe.
// Reports 'done' on the last handshake and 'timeout' when the engine stalls.
module omsp_spm_key_stream
    import omsp_spm_pkg::*;
#(
    parameter int KEY_WORDS    = KEY_WORDS_DEF,
    parameter int KEY_IDX_SIZE = KEY_IDX_SIZE_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic                    mclk,
    input  logic                    puc_rst,
    input  logic                    start,
    input  logic                    kd_valid,
    input  logic [15:0]             kd_data,
    output logic                    kd_ready,
    output logic                    done,
    output logic                    timeout,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx
);

    localparam logic [KEY_IDX_SIZE:0] LAST_WORD = (KEY_IDX_SIZE+1)'(KEY_WORDS - 1);
    localparam logic [7:0]            TMO_LAST  = 8'(TIMEOUT - 1);

    logic                    active_reg;
    logic [KEY_IDX_SIZE:0]   word_cnt_reg;
    logic [7:0]              tmo_cnt_reg;
    logic                    write_key_reg;
    logic [15:0]             key_in_reg;
    logic [KEY_IDX_SIZE-1:0] key_idx_reg;
    logic                    handshake;

    assign handshake = active_reg & kd_valid;
    assign kd_ready  = active_reg;
    // A handshake always beats a timeout: timeout only fires on an idle cycle.
    assign done      = handshake & (word_cnt_reg == LAST_WORD);
    assign timeout   = active_reg & ~kd_valid & (tmo_cnt_reg == TMO_LAST);

    assign write_key = write_key_reg;
    assign key_in    = key_in_reg;
    assign key_idx   = key_idx_reg;

    // Handshake, word/timeout counting and the registered SPM write stage.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            active_reg    <= 1'b0;
            word_cnt_reg  <= '0;
            tmo_cnt_reg   <= '0;
            write_key_reg <= 1'b0;
            key_in_reg    <= '0;
            key_idx_reg   <= '0;
        end else begin
            write_key_reg <= 1'b0;
            if (start) begin
                active_reg   <= 1'b1;
                word_cnt_reg <= '0;
                tmo_cnt_reg  <= '0;
            end else if (handshake) begin
                write_key_reg <= 1'b1;
                key_in_reg    <= kd_data;
                key_idx_reg   <= word_cnt_reg[KEY_IDX_SIZE-1:0];
                word_cnt_reg  <= word_cnt_reg + 1'b1;
                tmo_cnt_reg   <= '0;
                if (done) begin
                    active_reg <= 1'b0;
                end
            end else if (active_reg) begin
                // Stop counting at the abort so the counter never wraps.
                if (timeout) begin
                    active_reg <= 1'b0;
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/omsp_spm_cmd_seq.sv
// Protection command sequencer: runs one PROTECT / UNPROTECT / VERIFY command
// at a time, drives the SPM control strobes, streams the derived key on
// PROTECT and reports completion with a cmd_ack pulse and cmd_status.
module omsp_spm_cmd_seq
    import omsp_spm_pkg::*;
#(
    parameter int KEY_WORDS    = KEY_WORDS_DEF,
    parameter int KEY_IDX_SIZE = KEY_IDX_SIZE_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic                    mclk,
    input  logic                    puc_rst,
    input  logic                    cmd_req,
    input  logic [1:0]              cmd_op,
    output logic                    cmd_busy,
    output logic                    cmd_ack,
    output logic [1:0]              cmd_status,
    input  logic                    violation,
    output logic                    update_spm,
    output logic                    enable_spm,
    output logic                    disable_spm,
    output logic                    verify_spm,
    output logic                    kd_start,
    input  logic                    kd_valid,
    input  logic [15:0]             kd_data,
    output logic                    kd_ready,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx
);

    spm_state_t  state_reg;
    logic [1:0]  op_reg;
    logic        update_reg;
    logic        enable_reg;
    logic        disable_reg;
    logic        verify_reg;
    logic        ack_reg;
    logic [1:0]  status_reg;
    logic        ks_done;
    logic        ks_timeout;

    assign cmd_busy    = (state_reg != S_IDLE);
    assign cmd_ack     = ack_reg;
    assign cmd_status  = status_reg;
    assign update_spm  = update_reg;
    assign enable_spm  = enable_reg;
    assign disable_spm = disable_reg;
    assign verify_spm  = verify_reg;

    // kd_start depends on the violation sampled in the same CHECK cycle,
    // so it cannot be registered without adding a cycle of latency.
    assign kd_start = (state_reg == S_CHECK) & ~violation & (op_reg == OP_PROTECT);

    omsp_spm_key_stream #(
        .KEY_WORDS    (KEY_WORDS),
        .KEY_IDX_SIZE (KEY_IDX_SIZE),
        .TIMEOUT      (TIMEOUT)
    ) u_key_stream (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .start     (kd_start),
        .kd_valid  (kd_valid),
        .kd_data   (kd_data),
        .kd_ready  (kd_ready),
        .done      (ks_done),
        .timeout   (ks_timeout),
        .write_key (write_key),
        .key_in    (key_in),
        .key_idx   (key_idx)
    );

    // Command FSM; strobes are registered on entry to the state that owns them.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_reg   <= S_IDLE;
            op_reg      <= OP_PROTECT;
            update_reg  <= 1'b0;
            enable_reg  <= 1'b0;
            disable_reg <= 1'b0;
            verify_reg  <= 1'b0;
            ack_reg     <= 1'b0;
            status_reg  <= ST_OK;
        end else begin
            update_reg  <= 1'b0;
            enable_reg  <= 1'b0;
            disable_reg <= 1'b0;
            verify_reg  <= 1'b0;
            ack_reg     <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_req) begin
                        op_reg <= cmd_op;
                        case (cmd_op)
                            OP_PROTECT: begin
                                state_reg  <= S_UPDATE;
                                update_reg <= 1'b1;
                                enable_reg <= 1'b1;
                            end
                            OP_UNPROTECT: begin
                                state_reg   <= S_UPDATE;
                                update_reg  <= 1'b1;
                                disable_reg <= 1'b1;
                            end
                            OP_VERIFY: begin
                                state_reg  <= S_VERIFY;
                                verify_reg <= 1'b1;
                            end
                            default: begin
                                state_reg  <= S_DONE;
                                ack_reg    <= 1'b1;
                                status_reg <= ST_BADOP;
                            end
                        endcase
                    end
                end
                S_UPDATE: begin
                    state_reg <= S_CHECK;
                end
                S_CHECK: begin
                    if (violation) begin
                        state_reg  <= S_DONE;
                        ack_reg    <= 1'b1;
                        status_reg <= ST_VIOL;
                    end else if (op_reg == OP_UNPROTECT) begin
                        state_reg  <= S_DONE;
                        ack_reg    <= 1'b1;
                        status_reg <= ST_OK;
                    end else begin
                        state_reg <= S_KEYLOAD;
                    end
                end
                S_KEYLOAD: begin
                    if (ks_done) begin
                        state_reg  <= S_DONE;
                        ack_reg    <= 1'b1;
                        status_reg <= ST_OK;
                    end else if (ks_timeout) begin
                        state_reg  <= S_DONE;
                        ack_reg    <= 1'b1;
                        status_reg <= ST_TIMEOUT;
                    end
                end
                S_VERIFY: begin
                    state_reg  <= S_DONE;
                    ack_reg    <= 1'b1;
                    status_reg <= ST_OK;
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
